// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter with HLT freeze,
// decoded into the active-high/active-low control word for the datapath.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_n,
  output logic       CE_n,
  output logic       Li_n,
  output logic       Ei_n,
  output logic       La_n,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       load_b,
  output logic       load_out
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_r;
  logic    halted_r;

  logic cp_s, ep_s, lm_n_s, ce_n_s, li_n_s, ei_n_s;
  logic la_n_s, ea_s, su_s, eu_s, load_b_s, load_out_s;

  // Ring counter advance; HLT freezes the ring at T4 until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= T1;
      halted_r <= 1'b0;
    end else if (halted_r) begin
      state_r  <= state_r;
      halted_r <= 1'b1;
    end else begin
      halted_r <= 1'b0;
      case (state_r)
        T1: state_r <= T2;
        T2: state_r <= T3;
        T3: state_r <= T4;
        T4: begin
          if (opcode == OP_HLT) begin
            state_r  <= T4;
            halted_r <= 1'b1;
          end else begin
            state_r <= T5;
          end
        end
        T5: state_r <= T6;
        T6: state_r <= T1;
        default: state_r <= T1;
      endcase
    end
  end

  // Control word decode from T-state and opcode; inactive while halted.
  always_comb begin
    cp_s       = 1'b0;
    ep_s       = 1'b0;
    lm_n_s     = 1'b1;
    ce_n_s     = 1'b1;
    li_n_s     = 1'b1;
    ei_n_s     = 1'b1;
    la_n_s     = 1'b1;
    ea_s       = 1'b0;
    su_s       = 1'b0;
    eu_s       = 1'b0;
    load_b_s   = 1'b1;
    load_out_s = 1'b1;
    if (halted_r) begin
      cp_s = 1'b0;
    end else begin
      case (state_r)
        T1: begin
          ep_s   = 1'b1;
          lm_n_s = 1'b0;
        end
        T2: cp_s = 1'b1;
        T3: begin
          ce_n_s = 1'b0;
          li_n_s = 1'b0;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei_n_s = 1'b0;
              lm_n_s = 1'b0;
            end
            OP_OUT: begin
              ea_s       = 1'b1;
              load_out_s = 1'b0;
            end
            default: cp_s = 1'b0;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce_n_s = 1'b0;
              la_n_s = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ce_n_s   = 1'b0;
              load_b_s = 1'b0;
            end
            default: cp_s = 1'b0;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              eu_s   = 1'b1;
              la_n_s = 1'b0;
            end
            OP_SUB: begin
              eu_s   = 1'b1;
              la_n_s = 1'b0;
              su_s   = 1'b1;
            end
            default: cp_s = 1'b0;
          endcase
        end
        default: cp_s = 1'b0;
      endcase
    end
  end

  assign t_state  = state_r;
  assign halted   = halted_r;
  assign Cp       = cp_s;
  assign Ep       = ep_s;
  assign Lm_n     = lm_n_s;
  assign CE_n     = ce_n_s;
  assign Li_n     = li_n_s;
  assign Ei_n     = ei_n_s;
  assign La_n     = la_n_s;
  assign Ea       = ea_s;
  assign Su       = su_s;
  assign Eu       = eu_s;
  assign load_b   = load_b_s;
  assign load_out = load_out_s;

  sap_controller_checker u_chk (
    .clock   (clock),
    .reset   (reset),
    .t_state (state_r),
    .halted  (halted_r),
    .Ep      (ep_s),
    .CE_n    (ce_n_s),
    .Ei_n    (ei_n_s),
    .Ea      (ea_s),
    .Eu      (eu_s)
  );

endmodule

// Invariant checker: single bus driver, one-hot ring, halt only at T4.
module sap_controller_checker (
  input logic       clock,
  input logic       reset,
  input logic [5:0] t_state,
  input logic       halted,
  input logic       Ep,
  input logic       CE_n,
  input logic       Ei_n,
  input logic       Ea,
  input logic       Eu
);

  // Sample invariants each edge outside reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($countones({Ep, ~CE_n, ~Ei_n, Ea, Eu}) <= 1)
        else $error("bus driven by more than one source");
      assert ($onehot(t_state))
        else $error("t_state not one-hot");
      assert (!halted || (t_state == 6'b001000))
        else $error("halted outside T4");
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: per-cycle comparison against a step/halt model
// plus directed literal checks of each instruction's control words.
module tb_sap_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halted, Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, load_b, load_out;

  int checks = 0;
  int errors = 0;

  sap_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .t_state(t_state), .halted(halted),
    .Cp(Cp), .Ep(Ep), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
    .La_n(La_n), .Ea(Ea), .Su(Su), .Eu(Eu), .load_b(load_b), .load_out(load_out)
  );

  always #5 clock = ~clock;

  // Control word order {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,load_b,load_out}
  logic [11:0] ctrl;
  assign ctrl = {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, load_b, load_out};

  localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5,  EA = 4,  SU = 3, EU = 2, LB = 1, LO = 0;
  localparam logic [11:0] LOW_MASK = 12'b001111100011;

  localparam logic [11:0] C_IDLE   = 12'b001111100011;
  localparam logic [11:0] C_T1     = 12'b010111100011;
  localparam logic [11:0] C_T2     = 12'b101111100011;
  localparam logic [11:0] C_T3     = 12'b001001100011;
  localparam logic [11:0] C_MEMA   = 12'b000110100011;
  localparam logic [11:0] C_LDA5   = 12'b001011000011;
  localparam logic [11:0] C_ADD5   = 12'b001011100001;
  localparam logic [11:0] C_ADD6   = 12'b001111000111;
  localparam logic [11:0] C_SUB6   = 12'b001111001111;
  localparam logic [11:0] C_OUT4   = 12'b001111110010;

  // Model: which lines are asserted at instruction step 0..5 for an opcode.
  function automatic logic [11:0] asserted_lines(int step, logic [3:0] op, bit hlt);
    logic [11:0] m;
    bit alu, mem;
    m   = 12'd0;
    alu = (op == 4'b0001) || (op == 4'b0010);
    mem = alu || (op == 4'b0000);
    if (hlt) return m;
    case (step)
      0: begin m[EP] = 1'b1; m[LM] = 1'b1; end
      1: m[CP] = 1'b1;
      2: begin m[CE] = 1'b1; m[LI] = 1'b1; end
      3: begin
        if (mem) begin m[EI] = 1'b1; m[LM] = 1'b1; end
        if (op == 4'b1110) begin m[EA] = 1'b1; m[LO] = 1'b1; end
      end
      4: if (mem) begin m[CE] = 1'b1; if (alu) m[LB] = 1'b1; else m[LA] = 1'b1; end
      5: if (alu) begin m[EU] = 1'b1; m[LA] = 1'b1; m[SU] = (op == 4'b0010); end
      default: m = 12'd0;
    endcase
    return m;
  endfunction

  int m_step   = 0;
  bit m_halted = 1'b0;
  bit m_valid  = 1'b0;

  // Model state update on each rising edge.
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      m_step = 0; m_halted = 1'b0; m_valid = 1'b1;
    end else if (m_valid && !m_halted) begin
      if (m_step == 3 && opcode == 4'b1111) m_halted = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clock) begin
    if (m_valid) begin
      logic [11:0] exp_c;
      logic [5:0]  exp_t;
      exp_c = asserted_lines(m_step, opcode, m_halted) ^ LOW_MASK;
      exp_t = 6'd0;
      exp_t[m_step] = 1'b1;
      checks += 4;
      if (t_state !== exp_t) begin
        errors++; $display("FAIL model_t_state t=%0t got %b want %b", $time, t_state, exp_t);
      end
      if (halted !== m_halted) begin
        errors++; $display("FAIL model_halted t=%0t got %b want %b", $time, halted, m_halted);
      end
      if (ctrl !== exp_c) begin
        errors++; $display("FAIL model_ctrl t=%0t got %b want %b", $time, ctrl, exp_c);
      end
      if ($countones({Ep, ~CE_n, ~Ei_n, Ea, Eu}) > 1) begin
        errors++; $display("FAIL bus_excl t=%0t got %b want at most one", $time, {Ep, ~CE_n, ~Ei_n, Ea, Eu});
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Walk one full instruction from T1, checking literal control words.
  task automatic run_instr(input string nm, input logic [3:0] op,
                           input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    logic [11:0] exp_w [6];
    exp_w  = '{C_T1, C_T2, C_T3, e4, e5, e6};
    opcode = op;
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("%s_T%0d_state", nm, s + 1), {6'd0, t_state}, 12'd1 << s);
      chk($sformatf("%s_T%0d_ctrl", nm, s + 1), ctrl, exp_w[s]);
      tick();
    end
    chk({nm, "_wrap"}, {6'd0, t_state}, 12'b000000000001);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 4'bxxxx;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_state", {6'd0, t_state}, 12'b000000000001);
    chk("rst_halted", {11'd0, halted}, 12'd0);
    chk("fetch_T1", ctrl, C_T1);
    tick();
    chk("fetch_T2", ctrl, C_T2);
    tick();
    chk("fetch_T3", ctrl, C_T3);
    opcode = 4'b0000;
    tick();
    chk("lda_T4", ctrl, C_MEMA);
    tick();
    chk("lda_T5", ctrl, C_LDA5);
    tick();
    chk("lda_T6", ctrl, C_IDLE);
    tick();
    chk("lda_wrap", {6'd0, t_state}, 12'b000000000001);

    run_instr("lda", 4'b0000, C_MEMA, C_LDA5, C_IDLE);
    run_instr("sub", 4'b0010, C_MEMA, C_ADD5, C_SUB6);
    run_instr("add", 4'b0001, C_MEMA, C_ADD5, C_ADD6);
    run_instr("out", 4'b1110, C_OUT4, C_IDLE, C_IDLE);
    run_instr("nop", 4'b0101, C_IDLE, C_IDLE, C_IDLE);

    opcode = 4'b1111;
    repeat (3) tick();
    chk("hlt_T4_state", {6'd0, t_state}, 12'b000000001000);
    chk("hlt_T4_ctrl", ctrl, C_IDLE);
    chk("hlt_T4_halted", {11'd0, halted}, 12'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      opcode = 4'(i);
      chk($sformatf("hlt_hold%0d_state", i), {6'd0, t_state}, 12'b000000001000);
      chk($sformatf("hlt_hold%0d_halted", i), {11'd0, halted}, 12'd1);
      chk($sformatf("hlt_hold%0d_ctrl", i), ctrl, C_IDLE);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hlt_rst_state", {6'd0, t_state}, 12'b000000000001);
    chk("hlt_rst_halted", {11'd0, halted}, 12'd0);
    chk("hlt_rst_ctrl", ctrl, C_T1);

    opcode = 4'b0001;
    repeat (4) tick();
    chk("add_mid_T5", ctrl, C_ADD5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_state", {6'd0, t_state}, 12'b000000000001);
    chk("midrst_ctrl", ctrl, C_T1);
    run_instr("post_rst_add", 4'b0001, C_MEMA, C_ADD5, C_ADD6);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
Controller-sequencer for the SAP-1 datapath. A 6-state one-hot ring counter (T1..T6) runs a 3-state fetch followed by a 3-state opcode-dependent execute. The block decodes the current T-state and the instruction-register opcode nibble into the control word that drives the bus enables and register loads: PC, MAR, RAM, IR, accumulator, ALU, B register and output register. It sits directly upstream of the datapath and produces load_b, Ea, load_out and the remaining control lines.

Parameters:
OP_LDA, 4'b0000, load accumulator from RAM[addr]
OP_ADD, 4'b0001, A <= A + RAM[addr]
OP_SUB, 4'b0010, A <= A - RAM[addr]
OP_OUT, 4'b1110, output register <= A
OP_HLT, 4'b1111, stop sequencer

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clock
opcode  in  4  IR[7:4]; valid from T4 onward
t_state  out  6  one-hot ring state, bit0=T1 .. bit5=T6
halted  out  1  registered; 1 after HLT executes
Cp  out  1  PC increment, active-high
Ep  out  1  PC drives bus, active-high
Lm_n  out  1  MAR load, active-low
CE_n  out  1  RAM drives bus, active-low
Li_n  out  1  IR load, active-low
Ei_n  out  1  IR low nibble drives bus, active-low
La_n  out  1  accumulator load, active-low
Ea  out  1  accumulator drives bus, active-high
Su  out  1  ALU subtract select (1=subtract)
Eu  out  1  ALU drives bus, active-high
load_b  out  1  B register load, active-low
load_out  out  1  output register load, active-low

Behaviour:
- Reset (posedge with reset=1, any state, including mid-instruction or while halted): t_state=6'b000001, halted=0. Fetch restarts on the following cycle.
- Ring counter: advances one bit per posedge; T6 -> T1. No other transitions exist except HLT freeze.
- Control outputs are combinational decode of the registered t_state, halted and opcode. The datapath samples them on the next posedge.
- Inactive control word: Cp=Ep=Ea=Su=Eu=0; Lm_n=CE_n=Li_n=Ei_n=La_n=load_b=load_out=1. Any line not listed below for a state is inactive.
- Fetch, all opcodes:
  - T1: Ep=1, Lm_n=0
  - T2: Cp=1
  - T3: CE_n=0, Li_n=0
- LDA:
  - T4: Ei_n=0, Lm_n=0
  - T5: CE_n=0, La_n=0
  - T6: none
- ADD:
  - T4: Ei_n=0, Lm_n=0
  - T5: CE_n=0, load_b=0
  - T6: Eu=1, La_n=0, Su=0
- SUB: same as ADD, except T6 also drives Su=1.
- OUT:
  - T4: Ea=1, load_out=0
  - T5, T6: none
- HLT:
  - T4: control word inactive; halted set on the posedge that ends T4.
  - After that edge, t_state freezes at T4 and the control word stays inactive every cycle.
  - Only reset leaves this condition.
- Undefined opcodes: T4..T6 inactive (NOP); the ring counter wraps to T1 normally.
- Bus exclusivity (assertion): at most one of Ep, !CE_n, !Ei_n, Ea, Eu is active in any cycle.
- Invariants: t_state is always exactly one-hot; halted=1 implies t_state=T4.
- Opcode is ignored during T1..T3 and while halted.

Test Plan:
1. Reset 2 cycles, release, opcode=4'hX -> t_state=000001 with Ep=1, Lm_n=0; next cycle 000010 with Cp=1; next 000100 with CE_n=0, Li_n=0.
2. opcode=0000 (LDA) across T1..T6 -> T4: Ei_n=0, Lm_n=0; T5: CE_n=0, La_n=0; T6 all inactive; then t_state wraps to 000001.
3. opcode=0010 (SUB) -> T5: load_b=0, CE_n=0; T6: Eu=1, Su=1, La_n=0. Repeat with 0001 -> T6 Su=0.
4. opcode=1110 (OUT) -> T4: Ea=1, load_out=0 and no other lines active; T5 and T6 inactive.
5. opcode=1111 (HLT) -> halted=1 after T4 edge; t_state holds 001000 with inactive controls for 20 cycles; a reset pulse then gives t_state=000001, halted=0.
6. Reset asserted during T5 of ADD -> next cycle t_state=000001, load_b=1, La_n=1. Also: opcode=0101 -> T4..T6 inactive. The exclusivity and one-hot checks hold throughout all runs.
